instruction_loader: RTL and testbench

- Write-side counterpart of the fetch stage. It receives a program as a byte stream, for example from the UART debug path.
- It assembles the bytes into 32-bit words and writes them sequentially into the instruction RAM through the RAM's write port.
- While loading, it holds the fetch/pipeline stall. It releases the stall once the HALT word has been written, so fetch starts at address 0 with a fully loaded memory.

---
 rtl/instruction_loader.sv | 200 ++++++++++++++++++++
 tb/tb_instruction_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// Byte-stream program loader: packs big-endian bytes into words, writes them to instruction RAM,
// and holds fetch stalled until HALT is written. Optional macro: LOADER_CHECKSUM_EN.
module instruction_loader #(
    parameter int unsigned   len        = 32,
    parameter int unsigned   ADDR_WIDTH = 11,
    parameter logic [len-1:0] HALT_WORD = {len{1'b1}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_start,
    input  logic [7:0]            in_byte,
    input  logic                  in_byte_valid,
    output logic                  out_byte_ready,
    output logic                  out_wr_en,
    output logic [len-1:0]        out_wr_addr,
    output logic [len-1:0]        out_wr_data,
    output logic                  out_loading,
    output logic                  out_done,
    output logic                  out_error,
    output logic [ADDR_WIDTH:0]   out_word_count
);

    localparam int unsigned BYTES = len / 8;
    localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] MEM_WORDS = CNT_W'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_ERROR
`ifdef LOADER_CHECKSUM_EN
        , S_CHECK
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [len-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ready_q, ready_d;
    logic               wr_en_q, wr_en_d;
    logic [len-1:0]     wr_addr_q, wr_addr_d;
    logic [len-1:0]     wr_data_q, wr_data_d;
    logic               loading_q, loading_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [len-1:0]     xor_q, xor_d;
`endif

    logic [len-1:0]     shift_nx;
    logic               xfer;
    logic               last_byte;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            byte_idx_q <= '0;
            shift_q    <= '0;
            count_q    <= '0;
            ready_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            loading_q  <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            loading_q  <= loading_d;
            done_q     <= done_d;
            error_q    <= error_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= xor_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        count_d    = count_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        loading_d  = loading_q;
        done_d     = done_q;
        error_d    = error_q;
`ifdef LOADER_CHECKSUM_EN
        xor_d      = xor_q;
`endif
        shift_nx   = (shift_q << 8) | len'(in_byte);
        xfer       = in_byte_valid && ready_q;
        last_byte  = (byte_idx_q == IDX_W'(BYTES - 1));

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (in_start) begin
                    state_d    = S_RECV;
                    count_d    = '0;
                    byte_idx_d = '0;
                    shift_d    = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    loading_d  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    xor_d      = '0;
`endif
                end
            end
            S_RECV: begin
                if (xfer) begin
                    shift_d = shift_nx;
                    if (last_byte) begin
                        byte_idx_d = '0;
                        state_d    = S_WRITE;
                        wr_en_d    = 1'b1;
                        wr_addr_d  = len'({count_q, 2'b00});
                        wr_data_d  = shift_nx;
                    end else begin
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                    end
                end
            end
            S_WRITE: begin
                count_d = count_q + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
                xor_d   = xor_q ^ shift_q;
`endif
                // HALT wins over the memory-full check
                if (shift_q == HALT_WORD) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d   = S_CHECK;
`else
                    state_d   = S_DONE;
                    loading_d = 1'b0;
                    done_d    = 1'b1;
`endif
                end else if (count_d == MEM_WORDS) begin
                    state_d   = S_ERROR;
                    loading_d = 1'b0;
                    error_d   = 1'b1;
                end else begin
                    state_d   = S_RECV;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (xfer) begin
                    shift_d = shift_nx;
                    if (last_byte) begin
                        byte_idx_d = '0;
                        loading_d  = 1'b0;
                        if (shift_nx == xor_q) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_ERROR;
                            error_d = 1'b1;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

`ifdef LOADER_CHECKSUM_EN
        ready_d = (state_d == S_RECV) || (state_d == S_CHECK);
`else
        ready_d = (state_d == S_RECV);
`endif
    end

    assign out_byte_ready = ready_q;
    assign out_wr_en      = wr_en_q;
    assign out_wr_addr    = wr_addr_q;
    assign out_wr_data    = wr_data_q;
    assign out_loading    = loading_q;
    assign out_done       = done_q;
    assign out_error      = error_q;
    assign out_word_count = count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader (small memory, ADDR_WIDTH=2) with randomized programs.
module tb_instruction_loader;

    localparam int unsigned AW   = 2;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_start;
    logic [7:0]  in_byte;
    logic        in_byte_valid;
    logic        out_byte_ready;
    logic        out_wr_en;
    logic [31:0] out_wr_addr;
    logic [31:0] out_wr_data;
    logic        out_loading;
    logic        out_done;
    logic        out_error;
    logic [AW:0] out_word_count;

    instruction_loader #(.len(32), .ADDR_WIDTH(AW), .HALT_WORD(HALT)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_start       (in_start),
        .in_byte        (in_byte),
        .in_byte_valid  (in_byte_valid),
        .out_byte_ready (out_byte_ready),
        .out_wr_en      (out_wr_en),
        .out_wr_addr    (out_wr_addr),
        .out_wr_data    (out_wr_data),
        .out_loading    (out_loading),
        .out_done       (out_done),
        .out_error      (out_error),
        .out_word_count (out_word_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] prog[$];
    int          checks = 0;
    int          errors = 0;
    logic        prev_wr = 1'b0;
    wr_t         mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected write
    always @(negedge clk) begin
        if (reset && out_wr_en) begin
            chk("wr_en_single_cycle", 32'(prev_wr), 32'd0);
            chk("ready_low_in_write", 32'(out_byte_ready), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", out_wr_addr, mon_e.addr);
                chk("wr_data", out_wr_data, mon_e.data);
            end
        end
        prev_wr <= reset ? out_wr_en : 1'b0;
    end

    task automatic check_zero(input string tag);
        chk({tag, "_ready"},   32'(out_byte_ready), 32'd0);
        chk({tag, "_wr_en"},   32'(out_wr_en),      32'd0);
        chk({tag, "_addr"},    out_wr_addr,         32'd0);
        chk({tag, "_data"},    out_wr_data,         32'd0);
        chk({tag, "_loading"}, 32'(out_loading),    32'd0);
        chk({tag, "_done"},    32'(out_done),       32'd0);
        chk({tag, "_error"},   32'(out_error),      32'd0);
        chk({tag, "_count"},   32'(out_word_count), 32'd0);
    endtask

    task automatic pulse_start();
        in_start = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
    endtask

    // gap: 0 = back-to-back, 1 = valid toggles every other cycle, 2 = random idles
    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget = 0;
        if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) begin
            in_byte_valid = 1'b0;
            in_byte       = 8'($urandom);
            @(negedge clk);
        end
        in_byte       = b;
        in_byte_valid = 1'b1;
        while (!out_byte_ready && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 40) chk("byte_accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_byte_valid = 1'b0;
    endtask

    // cks_mode: 0 good checksum, 1 bad checksum, 2 random (only meaningful with LOADER_CHECKSUM_EN)
    task automatic run_load(input int gap, input bit mid_start, input int cks_mode);
        int          n = 0;
        int          budget = 0;
        bit          exp_done = 1'b0;
        bit          exp_err  = 1'b0;
        logic [31:0] w;
        logic [31:0] cks = 32'd0;

        // Reference: words are written in order until HALT or until memory holds 2**AW words
        foreach (prog[i]) begin
            if (exp_done || exp_err) break;
            exp_q.push_back({32'(i * 4), prog[i]});
            cks = cks ^ prog[i];
            n++;
            if (prog[i] == HALT) exp_done = 1'b1;
            else if (n == (1 << AW)) exp_err = 1'b1;
        end

        pulse_start();
        chk("start_loading", 32'(out_loading),    32'd1);
        chk("start_done",    32'(out_done),       32'd0);
        chk("start_error",   32'(out_error),      32'd0);
        chk("start_count",   32'(out_word_count), 32'd0);

        for (int k = 0; k < n; k++) begin
            w = prog[k];
            for (int b = 0; b < 4; b++) begin
                send_byte(w[31 - 8 * b -: 8], gap);
                if (mid_start && k == 0 && b == 1) pulse_start();
            end
        end

`ifdef LOADER_CHECKSUM_EN
        if (exp_done) begin
            bit bad;
            bad = (cks_mode == 1) || (cks_mode == 2 && $urandom_range(0, 1) == 1);
            if (bad) cks = cks ^ (32'd1 << $urandom_range(0, 31));
            for (int b = 0; b < 4; b++) send_byte(cks[31 - 8 * b -: 8], gap);
            exp_done = !bad;
            exp_err  = bad;
        end
`else
        if (cks_mode > 2) chk("cks_mode_range", 32'(cks_mode), 32'd0);
`endif

        while (!(out_done || out_error) && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 20) chk("end_of_load_timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("final_done",    32'(out_done),       32'(exp_done));
        chk("final_error",   32'(out_error),      32'(exp_err));
        chk("final_count",   32'(out_word_count), 32'(n));
        chk("final_loading", 32'(out_loading),    32'd0);
        chk("final_ready",   32'(out_byte_ready), 32'd0);
        chk("writes_pending", 32'(exp_q.size()),  32'd0);
        exp_q.delete();
    endtask

    initial begin
        reset         = 1'b0;
        in_start      = 1'b0;
        in_byte       = 8'd0;
        in_byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("por");
        reset = 1'b1;
        @(negedge clk);

        // Reset two bytes into a word: nothing written, everything back to zero
        pulse_start();
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        reset = 1'b0;
        #1;
        check_zero("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        prog = '{32'h0000_0001, HALT};
        run_load(0, 1'b0, 0);

        // Valid toggling every other cycle
        prog = '{32'h1234_5678, HALT};
        run_load(1, 1'b0, 0);

        // Memory fills without HALT
        prog = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        run_load(2, 1'b0, 0);

        // HALT in the last slot, start pulsed mid-load is ignored
        prog = '{32'hA5A5_0001, 32'h0000_0000, 32'hDEAD_BEEF, HALT};
        run_load(0, 1'b1, 0);

`ifdef LOADER_CHECKSUM_EN
        prog = '{32'h0000_000F, HALT};
        run_load(0, 1'b0, 0);
        prog = '{32'h0000_000F, HALT};
        run_load(0, 1'b0, 1);
`endif

        for (int t = 0; t < 25; t++) begin
            prog.delete();
            for (int i = 0; i < 6; i++)
                prog.push_back(($urandom_range(0, 3) == 0) ? HALT : 32'($urandom));
            run_load(2, ($urandom_range(0, 3) == 0), 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
